// File: rtl/gesture_lookup_mem.sv
// Gesture reference lookup memory: a table of reference sensor values with
// one valid bit per entry. A search scans the table one entry per clock and
// reports the lowest-indexed valid entry within TOL of the sampled key.
module gesture_lookup_mem #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned TOL    = 0,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    input  logic              search_start,
    input  logic [DATA_W-1:0] search_key,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [IDX_W:0]    valid_cnt
);

    localparam logic [DATA_W:0]  TolExt  = (DATA_W + 1)'(TOL);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [IDX_W:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]   key_q, key_d;
    logic                hit_q, hit_d;
    logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;

    logic                wr_ok;
    logic [DATA_W-1:0]   cur;
    logic [DATA_W:0]     diff;
    logic                match;

    // Out-of-range write addresses are dropped.
    assign wr_ok = wr_en && (32'(wr_idx) < DEPTH);

    // Entry data needs no reset; only the valid bits gate matching.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Valid bits and population count; a write wins over a same-cycle clear.
    always_comb begin
        valid_d = clr ? '0 : valid_q;
        cnt_d   = cnt_q;
        if (wr_ok) begin
            valid_d[wr_idx] = 1'b1;
        end
        if (clr) begin
            cnt_d = wr_ok ? (IDX_W + 1)'(1) : '0;
        end else if (wr_ok && !valid_q[wr_idx]) begin
            cnt_d = cnt_q + (IDX_W + 1)'(1);
        end
    end

    // Compare the registered entry (old contents on a same-cycle write) with the key.
    always_comb begin
        cur = mem_q[ptr_q];
        if (cur >= key_q) begin
            diff = {1'b0, cur} - {1'b0, key_q};
        end else begin
            diff = {1'b0, key_q} - {1'b0, cur};
        end
        match = valid_q[ptr_q] && (diff <= TolExt);
    end

    // Scan FSM next-state; result registers load only on entry to StDone.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        key_d     = key_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        unique case (state_q)
            StIdle: begin
                if (search_start) begin
                    state_d = StScan;
                    key_d   = search_key;
                    ptr_d   = '0;
                end
            end
            StScan: begin
                if (match) begin
                    state_d   = StDone;
                    hit_d     = 1'b1;
                    hit_idx_d = ptr_q;
                end else if (ptr_q == LastIdx) begin
                    state_d   = StDone;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            StDone: begin
                // A start in the done cycle chains straight into the next scan.
                if (search_start) begin
                    state_d = StScan;
                    key_d   = search_key;
                    ptr_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            valid_q   <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            key_q     <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            key_q     <= key_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    assign busy      = (state_q == StScan);
    assign done      = (state_q == StDone);
    assign hit       = hit_q;
    assign hit_idx   = hit_idx_q;
    assign valid_cnt = cnt_q;

endmodule

// File: tb/tb_gesture_lookup_mem.sv
// Directed bench: exact-match instance (TOL=0) and tolerance instance (TOL=3).
module tb_gesture_lookup_mem;

    localparam int DW = 64;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // exact-match instance
    logic          wr_en = 0, clr = 0, search_start = 0;
    logic [IW-1:0] wr_idx = '0;
    logic [DW-1:0] wr_data = '0, search_key = '0;
    logic          busy, done, hit;
    logic [IW-1:0] hit_idx;
    logic [IW:0]   valid_cnt;

    // tolerance instance
    logic          t_wr_en = 0, t_clr = 0, t_start = 0;
    logic [IW-1:0] t_wr_idx = '0;
    logic [DW-1:0] t_wr_data = '0, t_key = '0;
    logic          t_busy, t_done, t_hit;
    logic [IW-1:0] t_hit_idx;
    logic [IW:0]   t_valid_cnt;

    int n_total = 0;
    int n_pass  = 0;

    gesture_lookup_mem #(.DATA_W(64), .DEPTH(64), .TOL(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .clr(clr), .search_start(search_start), .search_key(search_key), .busy(busy),
        .done(done), .hit(hit), .hit_idx(hit_idx), .valid_cnt(valid_cnt)
    );

    gesture_lookup_mem #(.DATA_W(64), .DEPTH(64), .TOL(3)) dut_t (
        .clk(clk), .rst_n(rst_n), .wr_en(t_wr_en), .wr_idx(t_wr_idx), .wr_data(t_wr_data),
        .clr(t_clr), .search_start(t_start), .search_key(t_key), .busy(t_busy),
        .done(t_done), .hit(t_hit), .hit_idx(t_hit_idx), .valid_cnt(t_valid_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel_done(input bit t);
        return t ? t_done : done;
    endfunction

    function automatic logic sel_busy(input bit t);
        return t ? t_busy : busy;
    endfunction

    task automatic write(input bit t, input int idx, input logic [DW-1:0] data);
        if (t) begin
            t_wr_en = 1; t_wr_idx = IW'(idx); t_wr_data = data;
        end else begin
            wr_en = 1; wr_idx = IW'(idx); wr_data = data;
        end
        tick();
        wr_en = 0; t_wr_en = 0;
    endtask

    // Pulse start for one cycle; returns one cycle into the scan.
    task automatic start(input bit t, input logic [DW-1:0] key);
        if (t) begin
            t_start = 1; t_key = key;
        end else begin
            search_start = 1; search_key = key;
        end
        tick();
        search_start = 0; t_start = 0;
    endtask

    // lat counts edges from the start-sampling edge to the done cycle.
    task automatic wait_done(input bit t, output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = sel_busy(t) ? 1 : 0;
        while (!sel_done(t) && lat < 200) begin
            tick();
            lat++;
            if (sel_busy(t)) busy_cnt++;
        end
        if (lat >= 200) check_eq("done_timeout", 64'(lat), 64'(0));
    endtask

    int lat, bcnt, ndone;
    logic hit_seen;

    initial begin
        // reset
        #3;
        check_eq("rst_busy", 64'(busy), 0);
        check_eq("rst_done", 64'(done), 0);
        check_eq("rst_hit", 64'(hit), 0);
        check_eq("rst_hit_idx", 64'(hit_idx), 0);
        check_eq("rst_valid_cnt", 64'(valid_cnt), 0);
        tick();
        rst_n = 1;
        tick();

        // mem[i] = i, exact search for 5
        for (int i = 0; i <= 36; i++) write(0, i, 64'(i));
        check_eq("fill_valid_cnt", 64'(valid_cnt), 37);
        start(0, 64'd5);
        check_eq("hit5_busy", 64'(busy), 1);
        wait_done(0, lat, bcnt);
        check_eq("hit5_lat", 64'(lat), 7);
        check_eq("hit5_hit", 64'(hit), 1);
        check_eq("hit5_idx", 64'(hit_idx), 5);
        tick();
        check_eq("done_pulse", 64'(done), 0);
        check_eq("hit_hold", 64'(hit_idx), 5);

        // miss: full scan
        start(0, 64'd40);
        wait_done(0, lat, bcnt);
        check_eq("miss_lat", 64'(lat), 65);
        check_eq("miss_busy_cycles", 64'(bcnt), 64);
        check_eq("miss_hit", 64'(hit), 0);
        check_eq("miss_idx", 64'(hit_idx), 0);
        tick();

        // start pulsed mid-scan is dropped
        start(0, 64'd40);
        repeat (3) tick();
        search_start = 1; search_key = 64'd5;
        tick();
        search_start = 0;
        ndone = 0;
        hit_seen = 1'bx;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                ndone++;
                hit_seen = hit;
            end
            tick();
        end
        check_eq("ignored_start_dones", 64'(ndone), 1);
        check_eq("ignored_start_hit", 64'(hit_seen), 0);

        // back-to-back: start held in the done cycle
        start(0, 64'd5);
        wait_done(0, lat, bcnt);
        search_start = 1; search_key = 64'd6;
        tick();
        search_start = 0;
        check_eq("b2b_busy", 64'(busy), 1);
        wait_done(0, lat, bcnt);
        check_eq("b2b_lat", 64'(lat), 8);
        check_eq("b2b_idx", 64'(hit_idx), 6);
        tick();

        // tolerance instance: idx1=12, idx2=10, idx0=1
        write(1, 2, 64'd10);
        write(1, 1, 64'd12);
        start(1, 64'd13);
        wait_done(1, lat, bcnt);
        check_eq("tol13_hit", 64'(t_hit), 1);
        check_eq("tol13_idx", 64'(t_hit_idx), 1);
        check_eq("tol13_lat", 64'(lat), 3);
        tick();
        write(1, 0, 64'd1);
        start(1, 64'd15);
        wait_done(1, lat, bcnt);
        check_eq("tol15_edge_idx", 64'(t_hit_idx), 1);
        tick();
        start(1, 64'd7);
        wait_done(1, lat, bcnt);
        check_eq("tol7_idx", 64'(t_hit_idx), 2);
        tick();
        start(1, 64'd16);
        wait_done(1, lat, bcnt);
        check_eq("tol16_miss", 64'(t_hit), 0);
        tick();
        start(1, {DW{1'b1}});
        wait_done(1, lat, bcnt);
        check_eq("nowrap_hit", 64'(t_hit), 0);
        check_eq("nowrap_lat", 64'(lat), 65);
        check_eq("tol_valid_cnt", 64'(t_valid_cnt), 3);
        tick();

        // clr + write same cycle
        clr = 1; wr_en = 1; wr_idx = 6'd3; wr_data = 64'd7;
        tick();
        clr = 0; wr_en = 0;
        check_eq("clrwr_valid_cnt", 64'(valid_cnt), 1);
        start(0, 64'd7);
        wait_done(0, lat, bcnt);
        check_eq("clrwr_hit", 64'(hit), 1);
        check_eq("clrwr_idx", 64'(hit_idx), 3);
        tick();
        start(0, 64'd5);
        wait_done(0, lat, bcnt);
        check_eq("cleared_miss", 64'(hit), 0);
        tick();
        write(0, 3, 64'd9);
        check_eq("overwrite_cnt", 64'(valid_cnt), 1);
        start(0, 64'd9);
        wait_done(0, lat, bcnt);
        check_eq("overwrite_idx", 64'(hit_idx), 3);
        check_eq("overwrite_hit", 64'(hit), 1);
        tick();

        // reset mid-scan
        start(0, 64'd40);
        repeat (9) tick();
        #2;
        rst_n = 0;
        #1;
        check_eq("midrst_busy", 64'(busy), 0);
        check_eq("midrst_done", 64'(done), 0);
        check_eq("midrst_hit", 64'(hit), 0);
        check_eq("midrst_idx", 64'(hit_idx), 0);
        check_eq("midrst_cnt", 64'(valid_cnt), 0);
        repeat (2) tick();
        rst_n = 1;
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            if (done) ndone++;
            tick();
        end
        check_eq("midrst_no_done", 64'(ndone), 0);
        start(0, 64'd9);
        wait_done(0, lat, bcnt);
        check_eq("postrst_miss", 64'(hit), 0);
        check_eq("postrst_lat", 64'(lat), 65);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
